// File: rtl/zigzag_buffer.sv
// Ping-pong 8x8 coefficient buffer: raster-order writes into one bank while the
// other bank is read back in JPEG zigzag order.
module zigzag_buffer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_last,
  input  logic                         out_ready,
  output logic                         overflow
);

  // Bank select is the address MSB; reads are asynchronous so the first
  // coefficient is presented the cycle after its block completes.
  logic signed [DATA_WIDTH-1:0] mem_q [0:127];

  logic [1:0] full_q, full_d;
  logic       wbank_q, wbank_d;
  logic       rbank_q, rbank_d;
  logic [5:0] wcnt_q, wcnt_d;
  logic [5:0] rcnt_q, rcnt_d;
  logic       overflow_q, overflow_d;
  logic       wr_en, rd_en;

  function automatic logic [5:0] zz_addr(input logic [5:0] idx);
    logic [5:0] r;
    r = '0;
    case (idx)
      6'd0:  r = 6'd0;   6'd1:  r = 6'd1;   6'd2:  r = 6'd8;   6'd3:  r = 6'd16;
      6'd4:  r = 6'd9;   6'd5:  r = 6'd2;   6'd6:  r = 6'd3;   6'd7:  r = 6'd10;
      6'd8:  r = 6'd17;  6'd9:  r = 6'd24;  6'd10: r = 6'd32;  6'd11: r = 6'd25;
      6'd12: r = 6'd18;  6'd13: r = 6'd11;  6'd14: r = 6'd4;   6'd15: r = 6'd5;
      6'd16: r = 6'd12;  6'd17: r = 6'd19;  6'd18: r = 6'd26;  6'd19: r = 6'd33;
      6'd20: r = 6'd40;  6'd21: r = 6'd48;  6'd22: r = 6'd41;  6'd23: r = 6'd34;
      6'd24: r = 6'd27;  6'd25: r = 6'd20;  6'd26: r = 6'd13;  6'd27: r = 6'd6;
      6'd28: r = 6'd7;   6'd29: r = 6'd14;  6'd30: r = 6'd21;  6'd31: r = 6'd28;
      6'd32: r = 6'd35;  6'd33: r = 6'd42;  6'd34: r = 6'd49;  6'd35: r = 6'd56;
      6'd36: r = 6'd57;  6'd37: r = 6'd50;  6'd38: r = 6'd43;  6'd39: r = 6'd36;
      6'd40: r = 6'd29;  6'd41: r = 6'd22;  6'd42: r = 6'd15;  6'd43: r = 6'd23;
      6'd44: r = 6'd30;  6'd45: r = 6'd37;  6'd46: r = 6'd44;  6'd47: r = 6'd51;
      6'd48: r = 6'd58;  6'd49: r = 6'd59;  6'd50: r = 6'd52;  6'd51: r = 6'd45;
      6'd52: r = 6'd38;  6'd53: r = 6'd31;  6'd54: r = 6'd39;  6'd55: r = 6'd46;
      6'd56: r = 6'd53;  6'd57: r = 6'd60;  6'd58: r = 6'd61;  6'd59: r = 6'd54;
      6'd60: r = 6'd47;  6'd61: r = 6'd55;  6'd62: r = 6'd62;  6'd63: r = 6'd63;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign in_ready  = !full_q[wbank_q];
  assign out_valid = full_q[rbank_q];
  assign out_data  = mem_q[{rbank_q, zz_addr(rcnt_q)}];
  assign out_last  = out_valid && (rcnt_q == 6'd63);
  assign overflow  = overflow_q;

  assign wr_en = in_valid && in_ready;
  assign rd_en = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[{wbank_q, wcnt_q}] <= in_data;
    end
  end

  // A write only ever targets a non-full bank and a read only a full one, so a
  // same-cycle set and clear always land on different bits of full_d.
  always_comb begin
    full_d     = full_q;
    wbank_d    = wbank_q;
    rbank_d    = rbank_q;
    wcnt_d     = wcnt_q;
    rcnt_d     = rcnt_q;
    overflow_d = overflow_q;
    if (wr_en) begin
      wcnt_d = wcnt_q + 6'd1;
      if (wcnt_q == 6'd63) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = ~wbank_q;
      end
    end
    if (rd_en) begin
      rcnt_d = rcnt_q + 6'd1;
      if (rcnt_q == 6'd63) begin
        full_d[rbank_q] = 1'b0;
        rbank_d         = ~rbank_q;
      end
    end
    if (in_valid && !in_ready) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q     <= '0;
      wbank_q    <= 1'b0;
      rbank_q    <= 1'b0;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      full_q     <= full_d;
      wbank_q    <= wbank_d;
      rbank_q    <= rbank_d;
      wcnt_q     <= wcnt_d;
      rcnt_q     <= rcnt_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: doc/zigzag_buffer.md
ZIGZAG_BUFFER -- requirements
Module: zigzag_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: signed coefficient width, input and output.
REQ-002 SHALL have port clk  input  1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1: in_data holds a DCT coefficient this cycle.
REQ-005 SHALL have port in_data  input  DATA_WIDTH: signed coefficient, raster order within an 8x8 block (index = row*8+col, 0..63).
REQ-006 SHALL have port in_ready  output  1: high when the current write bank can accept a coefficient.
REQ-007 SHALL have port out_valid  output  1: out_data is a valid zigzag-ordered coefficient.
REQ-008 SHALL have port out_data  output  DATA_WIDTH: coefficient in JPEG zigzag order.
REQ-009 SHALL have port out_last  output  1: high with the 64th (zigzag index 63) coefficient of a block.
REQ-010 SHALL have port out_ready  input  1: consumer accepts out_data when out_valid & out_ready.
REQ-011 SHALL have port overflow  output  1: sticky; a coefficient was offered while in_ready was low.

Function
REQ-012 SHALL store coefficients in two 64-entry banks (ping-pong), each with a full flag.
REQ-013 SHALL accept input when in_valid & in_ready; write to mem[wbank][wcnt], then wcnt += 1.
REQ-014 SHALL drive in_ready = !full[wbank].
REQ-015 SHALL, on accepting with wcnt==63: set full[wbank], toggle wbank, set wcnt to 0.
REQ-016 SHALL drive out_valid = full[rbank]; out_data = mem[rbank][ZZ[rcnt]], where ZZ is the standard JPEG zigzag table (0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,40,48,41,34,27,20,13,6,7,14,21,28,35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63).
REQ-017 SHALL drive out_last = out_valid & (rcnt==63).
REQ-018 SHALL, on out_valid & out_ready: rcnt += 1; if rcnt==63, clear full[rbank], toggle rbank, set rcnt to 0.
REQ-019 SHALL hold out_data and out_last stable while out_valid & !out_ready.
REQ-020 SHALL assert out_valid for a block's first coefficient in the cycle after that block's 64th input is accepted (latency 1 cycle).
REQ-021 SHALL reach a steady throughput of 1 coefficient/cycle in and out with no bubbles when out_ready is held high.
REQ-022 SHALL handle a full-set on one bank and a full-clear on the other bank in the same cycle independently; neither event is lost.
REQ-023 SHALL drop data offered when in_valid & !in_ready: no write, no wcnt change, and overflow set to 1 until reset.
REQ-024 SHALL pass data values unmodified: no arithmetic, sign preserved bit-exact.
REQ-025 SHALL ignore in_data when in_valid is low and ignore out_ready when out_valid is low.

Reset
REQ-026 SHALL, on rst high, immediately clear full[0], full[1], wbank, rbank, wcnt, rcnt and overflow, including mid-block; partial blocks are discarded.
REQ-027 SHALL therefore, during and after reset, drive out_valid=0, out_last=0, in_ready=1 and overflow=0.
REQ-028 SHALL NOT need bank memory contents reset; out_data is don't-care while out_valid=0.

Verification
REQ-029 Ramp in_data 0..63, out_ready=1 -> out_valid rises 1 cycle after the 64th accept; out_data = 0,1,8,16,9,2,...,62,63; out_last only on value 63.
REQ-030 Three back-to-back blocks, out_ready=0 -> in_ready low after 128 accepts; the 129th offered coefficient is dropped and overflow=1 and stays 1.
REQ-031 Block with values -128..-65, random out_ready toggling -> out_data/out_last stable while stalled; zigzag sequence exact with no duplicates or skips.
REQ-032 Continuous stream of 4 blocks, out_ready=1 -> in_ready never low; output gapless after initial latency; out_last every 64 cycles.
REQ-033 Assert rst after 30 inputs of a block and again during output of a full block -> outputs return to reset values asynchronously; the next full block outputs correctly from zigzag index 0.
